// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the handshaked data-memory responder.
package data_mem_responder_pkg;

    // RV32I load/store size codes (stores reuse the signed encodings)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane steering for one 32-bit memory word: load extraction with
// sign/zero extension, store byte mask with shifted data, legality check.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_mask,
    output logic [31:0] wword,
    output logic        err
);

    logic [31:0] shifted;

    // Decode size, check alignment and steer the lanes
    always_comb begin
        shifted   = rword >> {off, 3'b000};
        wword     = wdata << {off, 3'b000};
        load_data = '0;
        byte_mask = '0;
        err       = 1'b0;
        case (fun3)
            F3_LB: begin
                load_data = {{24{shifted[7]}}, shifted[7:0]};
                byte_mask = 4'b0001 << off;
            end
            F3_LBU: begin
                load_data = {24'h000000, shifted[7:0]};
                err       = we;
            end
            F3_LH: begin
                load_data = {{16{shifted[15]}}, shifted[15:0]};
                byte_mask = 4'b0011 << off;
                err       = off[0];
            end
            F3_LHU: begin
                load_data = {16'h0000, shifted[15:0]};
                err       = off[0] | we;
            end
            F3_LW: begin
                load_data = rword;
                byte_mask = 4'b1111;
                err       = |off;
            end
            default: err = 1'b1;
        endcase
        if (err || !we) begin
            byte_mask = '0;
        end
        if (err || we) begin
            load_data = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked byte-addressable data memory with programmable wait states.
// Requests are latched in IDLE, delayed WAIT_CYCLES, performed in a single
// ACCESS cycle and the result is held in RESP until the consumer takes it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int MEM_BYTES = 2 ** ADDR_W;

    state_t              state, state_next;
    logic [CNT_W-1:0]    wait_cnt, cnt_inc;
    logic                lat_we;
    logic [2:0]          lat_fun3;
    logic [ADDR_W-1:0]   lat_addr;
    logic [31:0]         lat_wdata;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic [7:0]          mem [MEM_BYTES];
    logic [ADDR_W-3:0]   word_idx;
    logic [31:0]         rword, load_data, wword;
    logic [3:0]          byte_mask;
    logic                align_err;

    assign cnt_inc   = wait_cnt + CNT_W'(1);
    assign word_idx  = lat_addr[ADDR_W-1:2];
    // Aligned accesses stay inside one word, so the whole containing word
    // is fetched and the lane aligner picks the bytes out of it.
    assign rword     = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                        mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    mem_lane_align u_align (
        .fun3      (lat_fun3),
        .we        (lat_we),
        .off       (lat_addr[1:0]),
        .rword     (rword),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .byte_mask (byte_mask),
        .wword     (wword),
        .err       (align_err)
    );

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_inc == CNT_W'(WAIT_CYCLES)) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_fun3  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_fun3  <= req_fun3;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                    end
                end
                S_WAIT: wait_cnt <= cnt_inc;
                S_ACCESS: begin
                    rdata_q <= load_data;
                    err_q   <= align_err;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    // Byte-masked memory write; storage is never cleared by reset
    always_ff @(posedge clk) begin
        if (state == S_ACCESS) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_mask[i]) begin
                    mem[{word_idx, 2'(i)}] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule
